readout_arbiter: RTL and testbench

READOUT_ARBITER -- requirements
Module: readout_arbiter

---
 rtl/tdc_pkg.sv | 26 ++
 rtl/readout_arbiter_rr_pick.sv | 37 +++
 rtl/readout_arbiter.sv | 175 +++++++++++++++++
 tb/tb_readout_arbiter.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/tdc_pkg.sv
// ---------------------------------------------------------------------------
// tdc_pkg
// Shared definitions for the TDC readout path: default parameter values for
// the readout arbiter, the arbiter FSM state encoding, and a small index
// wrap helper used for the round-robin pointer.
// No ports (package).
// ---------------------------------------------------------------------------
package tdc_pkg;

    localparam int DEF_NCH     = 2;
    localparam int DEF_CNT_W   = 16;
    localparam int DEF_TIMEOUT = 1048575;

    typedef enum logic [1:0] {
        ST_IDLE        = 2'd0,
        ST_GRANT       = 2'd1,
        ST_WAIT_CH     = 2'd2,
        ST_WAIT_PC_LOW = 2'd3
    } state_t;

    // v + 1, wrapping to 0 when it reaches n.
    function automatic int wrap_inc(input int v, input int n);
        return (v + 1 >= n) ? 0 : v + 1;
    endfunction

endpackage

// File: rtl/readout_arbiter_rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
// Combinational round-robin picker: returns the first asserted request at or
// after ptr, wrapping from NCH-1 back to 0.
// Ports:
//   req   in  NCH    request vector
//   ptr   in  SEL_W  highest-priority index for this pick
//   valid out 1      at least one request is set
//   idx   out SEL_W  chosen index (0 when valid is low)
// ---------------------------------------------------------------------------
module rr_pick #(
    parameter int NCH   = 2,
    parameter int SEL_W = 1
) (
    input  logic [NCH-1:0]   req,
    input  logic [SEL_W-1:0] ptr,
    output logic             valid,
    output logic [SEL_W-1:0] idx
);

    always_comb begin
        logic [SEL_W-1:0] cand;
        valid = 1'b0;
        idx   = '0;
        cand  = '0;
        // Scan from the farthest offset down to ptr itself so the closest
        // requester (lowest offset) is the last one written and wins.
        for (int off = NCH - 1; off >= 0; off--) begin
            cand = SEL_W'((int'(ptr) + off) % NCH);
            if (req[cand]) begin
                valid = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/readout_arbiter.sv
// ---------------------------------------------------------------------------
// readout_arbiter
// Shares one PC readout handshake between NCH data channels. A ready channel
// is granted round-robin, its index is exported on ch_sel to steer the shared
// DPRAM read mux, and the four-phase handshake is relayed between the PC and
// the granted channel.
//
// Handshake (four-phase, level based):
//   channel raises ch_ready[k] -> arbiter grants k, raises pc_ready
//   PC raises pc_ack           -> arbiter drops pc_ready, raises ch_ack[k]
//   channel drops ch_ready[k]  -> arbiter drops ch_ack[k], counts the frame
//   PC drops pc_ack            -> arbiter returns to IDLE, pointer moves past k
//
// Ports:
//   SYSCLK      in  1          clock, rising edge
//   RESET       in  1          asynchronous, active-high reset
//   enable      in  1          allow new grants (never aborts a transaction)
//   ch_ready    in  NCH        per-channel frame-ready level
//   ch_ack      out NCH        per-channel acknowledge (at most one high)
//   pc_ready    out 1          frame-ready flag towards the PC
//   pc_ack      in  1          PC acknowledge, asynchronous to SYSCLK
//   ch_sel      out SEL_W      granted channel index
//   busy        out 1          FSM not in IDLE
//   timeout_err out 1          sticky: PC failed to acknowledge a grant
//   frame_count out NCH*CNT_W  completed frames, channel k at [k*CNT_W +: CNT_W]
//   state_dbg   out 2          current FSM state, for observation only
// ---------------------------------------------------------------------------
module readout_arbiter
    import tdc_pkg::*;
#(
    parameter int NCH     = DEF_NCH,
    parameter int CNT_W   = DEF_CNT_W,
    parameter int TIMEOUT = DEF_TIMEOUT,
    parameter int SEL_W   = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                 SYSCLK,
    input  logic                 RESET,
    input  logic                 enable,
    input  logic [NCH-1:0]       ch_ready,
    output logic [NCH-1:0]       ch_ack,
    output logic                 pc_ready,
    input  logic                 pc_ack,
    output logic [SEL_W-1:0]     ch_sel,
    output logic                 busy,
    output logic                 timeout_err,
    output logic [NCH*CNT_W-1:0] frame_count,
    output state_t               state_dbg
);

    localparam int TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    state_t           state_q, state_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [SEL_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic             timeout_err_q, timeout_err_d;
    logic             ack_s1_q, ack_s2_q;
    logic [NCH-1:0]   count_en;
    logic             pick_valid;
    logic [SEL_W-1:0] pick_idx;
    logic [SEL_W-1:0] sel_next;

    rr_pick #(
        .NCH   (NCH),
        .SEL_W (SEL_W)
    ) u_rr_pick (
        .req   (ch_ready),
        .ptr   (rr_ptr_q),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    assign sel_next = SEL_W'(wrap_inc(int'(sel_q), NCH));

    // pc_ack comes from the IPbus clock domain.
    always_ff @(posedge SYSCLK or posedge RESET) begin
        if (RESET) begin
            ack_s1_q <= 1'b0;
            ack_s2_q <= 1'b0;
        end else begin
            ack_s1_q <= pc_ack;
            ack_s2_q <= ack_s1_q;
        end
    end

    always_ff @(posedge SYSCLK or posedge RESET) begin
        if (RESET) begin
            state_q       <= ST_IDLE;
            sel_q         <= '0;
            rr_ptr_q      <= '0;
            tmo_cnt_q     <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            sel_q         <= sel_d;
            rr_ptr_q      <= rr_ptr_d;
            tmo_cnt_q     <= tmo_cnt_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        sel_d         = sel_q;
        rr_ptr_d      = rr_ptr_q;
        tmo_cnt_d     = '0;
        timeout_err_d = timeout_err_q;
        count_en      = '0;

        unique case (state_q)
            ST_IDLE: begin
                if (enable && pick_valid) begin
                    sel_d   = pick_idx;
                    state_d = ST_GRANT;
                end
            end
            ST_GRANT: begin
                // A withdrawn frame takes precedence: nothing was read, so
                // the same channel keeps its priority.
                if (!ch_ready[sel_q]) begin
                    state_d = ST_IDLE;
                end else if (ack_s2_q) begin
                    state_d = ST_WAIT_CH;
                end else if (tmo_cnt_q == TMO_W'(TIMEOUT - 1)) begin
                    timeout_err_d = 1'b1;
                    rr_ptr_d      = sel_next;
                    state_d       = ST_IDLE;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
                end
            end
            ST_WAIT_CH: begin
                if (!ch_ready[sel_q]) begin
                    count_en[sel_q] = 1'b1;
                    state_d         = ST_WAIT_PC_LOW;
                end
            end
            ST_WAIT_PC_LOW: begin
                if (!ack_s2_q) begin
                    rr_ptr_d = sel_next;
                    state_d  = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs decode the state register only, so an asynchronous RESET
    // clears them in the same cycle.
    always_comb begin
        ch_ack = '0;
        if (state_q == ST_WAIT_CH) begin
            ch_ack[sel_q] = 1'b1;
        end
    end

    assign pc_ready    = (state_q == ST_GRANT);
    assign busy        = (state_q != ST_IDLE);
    assign ch_sel      = sel_q;
    assign timeout_err = timeout_err_q;
    assign state_dbg   = state_q;

    for (genvar k = 0; k < NCH; k++) begin : g_cnt
        logic [CNT_W-1:0] cnt_q;
        always_ff @(posedge SYSCLK or posedge RESET) begin
            if (RESET) begin
                cnt_q <= '0;
            end else if (count_en[k]) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
        assign frame_count[k*CNT_W +: CNT_W] = cnt_q;
    end

endmodule

// File: tb/tb_readout_arbiter.sv
module tb_readout_arbiter;
    import tdc_pkg::*;

    localparam int NCH     = 2;
    localparam int CNT_W   = 4;
    localparam int TIMEOUT = 16;
    localparam int SEL_W   = 1;
    localparam int NVEC    = 17;

    logic                 SYSCLK;
    logic                 RESET;
    logic                 enable;
    logic [NCH-1:0]       ch_ready;
    logic [NCH-1:0]       ch_ack;
    logic                 pc_ready;
    logic                 pc_ack;
    logic [SEL_W-1:0]     ch_sel;
    logic                 busy;
    logic                 timeout_err;
    logic [NCH*CNT_W-1:0] frame_count;
    state_t               state_dbg;

    int n_checks = 0;
    int n_pass   = 0;

    // {pc_ready, ch_ack, ch_sel, busy, frame_count}
    logic [12:0]      exp_q[$];
    logic [SEL_W-1:0] grant_q[$];

    typedef struct {
        logic       en;
        logic [1:0] rdy;
        logic       ack;
        logic       x_pc_ready;
        logic [1:0] x_ch_ack;
        logic       x_sel;
        logic       x_busy;
        logic [7:0] x_fc;
    } vec_t;

    vec_t vecs[NVEC];

    readout_arbiter #(
        .NCH     (NCH),
        .CNT_W   (CNT_W),
        .TIMEOUT (TIMEOUT),
        .SEL_W   (SEL_W)
    ) dut (
        .SYSCLK      (SYSCLK),
        .RESET       (RESET),
        .enable      (enable),
        .ch_ready    (ch_ready),
        .ch_ack      (ch_ack),
        .pc_ready    (pc_ready),
        .pc_ack      (pc_ack),
        .ch_sel      (ch_sel),
        .busy        (busy),
        .timeout_err (timeout_err),
        .frame_count (frame_count),
        .state_dbg   (state_dbg)
    );

    // ---------------- clock / reset ----------------
    initial SYSCLK = 1'b0;
    always #5 SYSCLK = ~SYSCLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge SYSCLK);
        #1;
    endtask

    task automatic do_reset();
        RESET    = 1'b1;
        enable   = 1'b0;
        ch_ready = '0;
        pc_ack   = 1'b0;
        tick();
        tick();
        RESET = 1'b0;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // ---------------- driver: one PC + channel transaction ----------------
    task automatic run_frame(input logic rearm);
        int               n;
        logic [SEL_W-1:0] exp_sel;
        logic [SEL_W-1:0] k;
        n = 0;
        while (pc_ready !== 1'b1 && n < 100) begin tick(); n++; end
        check("grant_wait", 32'(pc_ready), 32'd1);
        exp_sel = (grant_q.size() > 0) ? grant_q.pop_front() : 'x;
        check("grant_sel", 32'(ch_sel), 32'(exp_sel));
        k      = ch_sel;
        pc_ack = 1'b1;
        n = 0;
        while (ch_ack === '0 && n < 20) begin tick(); n++; end
        check("ack_onehot", 32'(ch_ack), 32'(2'b01 << exp_sel));
        check("ack_pc_ready_low", 32'(pc_ready), 32'd0);
        ch_ready[k] = 1'b0;
        n = 0;
        while (ch_ack !== '0 && n < 20) begin tick(); n++; end
        check("ack_clear", 32'(ch_ack), 32'd0);
        pc_ack = 1'b0;
        n = 0;
        while (busy !== 1'b0 && n < 20) begin tick(); n++; end
        check("idle_return", 32'(busy), 32'd0);
        if (rearm) ch_ready[k] = 1'b1;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [12:0] exp_v;
        logic        ack_hi;
        int          n;

        //             en    rdy    ack   pc_rdy ch_ack sel   busy  fc
        vecs[0]  = '{1'b1, 2'b01, 1'b0, 1'b1, 2'b00, 1'b0, 1'b1, 8'h00};
        vecs[1]  = '{1'b1, 2'b01, 1'b1, 1'b1, 2'b00, 1'b0, 1'b1, 8'h00};
        vecs[2]  = '{1'b1, 2'b01, 1'b1, 1'b1, 2'b00, 1'b0, 1'b1, 8'h00};
        vecs[3]  = '{1'b1, 2'b01, 1'b1, 1'b0, 2'b01, 1'b0, 1'b1, 8'h00};
        vecs[4]  = '{1'b1, 2'b00, 1'b1, 1'b0, 2'b00, 1'b0, 1'b1, 8'h01};
        vecs[5]  = '{1'b1, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 8'h01};
        vecs[6]  = '{1'b1, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 8'h01};
        vecs[7]  = '{1'b1, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 8'h01};
        vecs[8]  = '{1'b0, 2'b11, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 8'h01};
        vecs[9]  = '{1'b1, 2'b11, 1'b0, 1'b1, 2'b00, 1'b1, 1'b1, 8'h01};
        vecs[10] = '{1'b1, 2'b01, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 8'h01};
        vecs[11] = '{1'b1, 2'b11, 1'b0, 1'b1, 2'b00, 1'b1, 1'b1, 8'h01};
        vecs[12] = '{1'b0, 2'b11, 1'b0, 1'b1, 2'b00, 1'b1, 1'b1, 8'h01};
        vecs[13] = '{1'b0, 2'b01, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 8'h01};
        vecs[14] = '{1'b0, 2'b11, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 8'h01};
        vecs[15] = '{1'b1, 2'b01, 1'b0, 1'b1, 2'b00, 1'b0, 1'b1, 8'h01};
        vecs[16] = '{1'b1, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 8'h01};

        // Reset state, sampled while RESET is held.
        RESET    = 1'b1;
        enable   = 1'b0;
        ch_ready = '0;
        pc_ack   = 1'b0;
        tick();
        check("rst_pc_ready", 32'(pc_ready), 32'd0);
        check("rst_ch_ack", 32'(ch_ack), 32'd0);
        check("rst_ch_sel", 32'(ch_sel), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_timeout_err", 32'(timeout_err), 32'd0);
        check("rst_frame_count", 32'(frame_count), 32'd0);
        check("rst_state", 32'(state_dbg), 32'(ST_IDLE));
        tick();
        RESET = 1'b0;

        // Table: single frame, enable gating, withdraw in GRANT.
        for (int i = 0; i < NVEC; i++) begin
            enable   = vecs[i].en;
            ch_ready = vecs[i].rdy;
            pc_ack   = vecs[i].ack;
            exp_q.push_back({vecs[i].x_pc_ready, vecs[i].x_ch_ack, vecs[i].x_sel,
                             vecs[i].x_busy, vecs[i].x_fc});
            tick();
            exp_v = exp_q.pop_front();
            check($sformatf("vec%0d {pc_ready,ch_ack,ch_sel,busy,frame_count}", i),
                  32'({pc_ready, ch_ack, ch_sel, busy, frame_count}), 32'(exp_v));
        end

        // Simultaneous requests: grant order 0,1,0,1.
        do_reset();
        enable   = 1'b1;
        ch_ready = 2'b11;
        grant_q.push_back(1'b0);
        grant_q.push_back(1'b1);
        grant_q.push_back(1'b0);
        grant_q.push_back(1'b1);
        for (int f = 0; f < 4; f++) run_frame(1'b1);
        check("rr_frame_count", 32'(frame_count), 32'h22);

        // Counter wrap at 2^CNT_W on channel 0.
        do_reset();
        enable   = 1'b1;
        ch_ready = 2'b01;
        for (int f = 0; f < 16; f++) begin
            grant_q.push_back(1'b0);
            run_frame(1'b1);
            if (f == 14) check("wrap_pre", 32'(frame_count), 32'h0F);
        end
        check("wrap_post", 32'(frame_count), 32'h00);

        // Timeout: channel 1 ready, PC silent.
        do_reset();
        enable   = 1'b1;
        ch_ready = 2'b10;
        ack_hi   = 1'b0;
        for (int c = 1; c <= TIMEOUT; c++) begin
            tick();
            ack_hi = ack_hi | (ch_ack != '0);
            if (c == 1) check("tmo_grant_sel", 32'(ch_sel), 32'd1);
            if (c == TIMEOUT) begin
                check("tmo_pc_ready_last", 32'(pc_ready), 32'd1);
                check("tmo_err_before", 32'(timeout_err), 32'd0);
            end
        end
        tick();
        ack_hi = ack_hi | (ch_ack != '0);
        check("tmo_pc_ready", 32'(pc_ready), 32'd0);
        check("tmo_err", 32'(timeout_err), 32'd1);
        check("tmo_busy", 32'(busy), 32'd0);
        enable = 1'b0;
        tick();
        tick();
        check("tmo_err_sticky", 32'(timeout_err), 32'd1);
        check("tmo_frame_count", 32'(frame_count), 32'd0);
        check("tmo_ack_never", 32'(ack_hi), 32'd0);

        // Reset in WAIT_CH.
        do_reset();
        enable   = 1'b1;
        ch_ready = 2'b01;
        grant_q.push_back(1'b0);
        run_frame(1'b0);
        check("mid_pre_count", 32'(frame_count), 32'h01);
        ch_ready = 2'b01;
        pc_ack   = 1'b1;
        n = 0;
        while (ch_ack === '0 && n < 30) begin tick(); n++; end
        check("mid_in_wait_ch", 32'(state_dbg), 32'(ST_WAIT_CH));
        #3;
        RESET = 1'b1;
        #1;
        check("mid_ch_ack", 32'(ch_ack), 32'd0);
        check("mid_pc_ready", 32'(pc_ready), 32'd0);
        check("mid_frame_count", 32'(frame_count), 32'd0);
        check("mid_busy", 32'(busy), 32'd0);
        ch_ready = '0;
        pc_ack   = 1'b0;
        tick();
        RESET = 1'b0;
        tick();
        check("mid_state_after", 32'(state_dbg), 32'(ST_IDLE));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
